// File: rtl/lcd_blob_stats_if.sv
// LCD stream snoop and published blob statistics for lcd_blob_stats.
// Signal names follow the LCD timing controller naming (i* = into the engine, o* = out).
interface lcd_blob_stats_if;
  logic        iHD;
  logic        iVD;
  logic        iDEN;
  logic [7:0]  iPIX;
  logic [7:0]  iThresh;
  logic        oValid;
  logic        oEmpty;
  logic [18:0] oCount;
  logic [9:0]  oXMin;
  logic [9:0]  oXMax;
  logic [8:0]  oYMin;
  logic [8:0]  oYMax;
  logic [29:0] oXSum;
  logic [29:0] oYSum;

  modport master (
    output iHD, iVD, iDEN, iPIX, iThresh,
    input  oValid, oEmpty, oCount, oXMin, oXMax, oYMin, oYMax, oXSum, oYSum
  );

  modport slave (
    input  iHD, iVD, iDEN, iPIX, iThresh,
    output oValid, oEmpty, oCount, oXMin, oXMax, oYMin, oYMax, oXSum, oYSum
  );
endinterface

// File: rtl/lcd_blob_stats.sv
// Per-frame hit count / bounding box of an LCD stream, published at each frame start.
// Define LCD_BLOB_CENTROID_EN to build the x/y coordinate sum accumulators.
module lcd_blob_stats #(
  parameter int H_ACT = 800,
  parameter int V_ACT = 480
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  lcd_blob_stats_if.slave lcd
);
  localparam logic [9:0]  X_LAST  = 10'(H_ACT - 1);
  localparam logic [8:0]  Y_LAST  = 9'(V_ACT - 1);
  localparam logic [18:0] CNT_MAX = '1;

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state_q;

  logic        vd_q, den_q;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [18:0] cnt_q, cnt_d;
  logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d;
  logic [8:0]  ymin_q, ymin_d, ymax_q, ymax_d;
  logic        fs, hit, publish;
  logic [8:0]  hit_y;

  logic        valid_q, empty_q;
  logic [18:0] pub_cnt_q;
  logic [9:0]  pub_xmin_q, pub_xmax_q;
  logic [8:0]  pub_ymin_q, pub_ymax_q;

  always_comb begin
    fs      = vd_q & ~lcd.iVD;
    hit     = lcd.iDEN & (lcd.iPIX > lcd.iThresh);
    publish = fs & (state_q == ACCUM);
    // A hit coinciding with frame start is counted as row 0 of the new frame.
    hit_y   = fs ? '0 : y_q;

    if (!lcd.iDEN || !lcd.iHD) x_d = '0;
    else if (x_q == X_LAST)    x_d = x_q;
    else                       x_d = x_q + 10'd1;

    if (fs)                                        y_d = '0;
    else if (den_q && !lcd.iDEN && y_q != Y_LAST)  y_d = y_q + 9'd1;
    else                                           y_d = y_q;

    cnt_d  = fs ? '0     : cnt_q;
    xmin_d = fs ? X_LAST : xmin_q;
    xmax_d = fs ? '0     : xmax_q;
    ymin_d = fs ? Y_LAST : ymin_q;
    ymax_d = fs ? '0     : ymax_q;
    if (hit) begin
      if (cnt_d == '0) begin
        xmin_d = x_q;
        xmax_d = x_q;
        ymin_d = hit_y;
        ymax_d = hit_y;
      end else begin
        if (x_q < xmin_d)   xmin_d = x_q;
        if (x_q > xmax_d)   xmax_d = x_q;
        if (hit_y < ymin_d) ymin_d = hit_y;
        if (hit_y > ymax_d) ymax_d = hit_y;
      end
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + 19'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= IDLE;
      vd_q       <= 1'b1;
      den_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      xmin_q     <= X_LAST;
      xmax_q     <= '0;
      ymin_q     <= Y_LAST;
      ymax_q     <= '0;
      valid_q    <= 1'b0;
      empty_q    <= 1'b1;
      pub_cnt_q  <= '0;
      pub_xmin_q <= '0;
      pub_xmax_q <= '0;
      pub_ymin_q <= '0;
      pub_ymax_q <= '0;
    end else begin
      vd_q    <= lcd.iVD;
      den_q   <= lcd.iDEN;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (fs) state_q <= ACCUM;
        ACCUM: if (fs) begin
          valid_q    <= 1'b1;
          empty_q    <= (cnt_q == '0);
          pub_cnt_q  <= cnt_q;
          pub_xmin_q <= (cnt_q == '0) ? '0 : xmin_q;
          pub_xmax_q <= (cnt_q == '0) ? '0 : xmax_q;
          pub_ymin_q <= (cnt_q == '0) ? '0 : ymin_q;
          pub_ymax_q <= (cnt_q == '0) ? '0 : ymax_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lcd.oValid = valid_q;
  assign lcd.oEmpty = empty_q;
  assign lcd.oCount = pub_cnt_q;
  assign lcd.oXMin  = pub_xmin_q;
  assign lcd.oXMax  = pub_xmax_q;
  assign lcd.oYMin  = pub_ymin_q;
  assign lcd.oYMax  = pub_ymax_q;

`ifdef LCD_BLOB_CENTROID_EN
  logic [29:0] xsum_q, ysum_q, pub_xsum_q, pub_ysum_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      xsum_q     <= '0;
      ysum_q     <= '0;
      pub_xsum_q <= '0;
      pub_ysum_q <= '0;
    end else begin
      xsum_q <= (fs ? 30'd0 : xsum_q) + (hit ? {20'd0, x_q} : 30'd0);
      ysum_q <= (fs ? 30'd0 : ysum_q) + (hit ? {21'd0, hit_y} : 30'd0);
      if (publish) begin
        pub_xsum_q <= (cnt_q == '0) ? '0 : xsum_q;
        pub_ysum_q <= (cnt_q == '0) ? '0 : ysum_q;
      end
    end
  end

  assign lcd.oXSum = pub_xsum_q;
  assign lcd.oYSum = pub_ysum_q;
`else
  logic unused_publish;
  assign unused_publish = publish;
  assign lcd.oXSum      = '0;
  assign lcd.oYSum      = '0;
`endif
endmodule

// File: tb/tb_lcd_blob_stats.sv
// Directed frame-level bench for lcd_blob_stats using a reduced 104x52 active raster.
module tb_lcd_blob_stats;
  localparam int H_ACT   = 104;
  localparam int V_ACT   = 52;
  localparam int H_BLANK = 4;
  localparam int LINE    = H_ACT + H_BLANK;

  logic iCLK = 1'b0;
  logic iRST_n = 1'b0;

  lcd_blob_stats_if bif();

  lcd_blob_stats #(.H_ACT(H_ACT), .V_ACT(V_ACT)) dut (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .lcd   (bif)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int cnt;
    int xmin, xmax, ymin, ymax;
    int xsum, ysum;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   armed = 1'b0;
  int   m_cnt, m_xmin, m_xmax, m_ymin, m_ymax, m_xsum, m_ysum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [7:0] pixval(input int mode, input int x, input int y);
    case (mode)
      1: return (x == 100 && y == 50) ? 8'd200 : 8'd0;
      2: return (x >= 10 && x <= 19 && y >= 5 && y <= 8) ? 8'd255 : 8'd0;
      3: return 8'd128;
      4: return (y == 3 && x >= H_ACT - 2) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic model_hit(input int x, input int y);
    if (m_cnt == 0) begin
      m_xmin = x; m_xmax = x; m_ymin = y; m_ymax = y;
    end else begin
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end
    m_cnt++;
    m_xsum += x;
    m_ysum += y;
  endtask

  // Drives one sync line plus one back-porch line; checks oValid on the FS edge.
  task automatic vsync();
    tick();
    bif.iVD  = 1'b0;
    bif.iDEN = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    check("valid_at_fs", bif.oValid, armed);
    armed = 1'b1;
    m_cnt = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_xsum = 0; m_ysum = 0;
    repeat (LINE - 2) tick();
    bif.iVD = 1'b1;
    repeat (LINE) tick();
  endtask

  task automatic do_reset();
    iRST_n = 1'b0;
    @(negedge iCLK);
    check("rst_mid_valid", bif.oValid, 1'b0);
    check("rst_mid_empty", bif.oEmpty, 1'b1);
    check("rst_mid_count", bif.oCount, 0);
    check("rst_mid_xmax", bif.oXMax, 0);
    tick();
    tick();
    iRST_n = 1'b1;
    armed = 1'b0;
  endtask

  task automatic run_frame(input int mode, input logic [7:0] thr, input int rst_line);
    res_t r;
    int   len;
    logic [7:0] p;
    vsync();
    bif.iThresh = thr;
    for (int y = 0; y < V_ACT; y++) begin
      len = (mode == 4 && y == 3) ? H_ACT + 6 : H_ACT;
      for (int x = 0; x < len; x++) begin
        p = pixval(mode, x, y);
        bif.iDEN = 1'b1;
        bif.iPIX = p;
        if (p > thr) model_hit((x < H_ACT) ? x : H_ACT - 1, y);
        if (y == rst_line && x == 10) do_reset();
        tick();
      end
      bif.iDEN = 1'b0;
      bif.iPIX = 8'd0;
      bif.iHD  = 1'b0;
      tick();
      bif.iHD  = 1'b1;
      repeat (H_BLANK - 1) tick();
    end
    if (armed) begin
      if (m_cnt == 0) r = '{0, 0, 0, 0, 0, 0, 0};
      else            r = '{m_cnt, m_xmin, m_xmax, m_ymin, m_ymax, m_xsum, m_ysum};
      exp_q.push_back(r);
    end
  endtask

  always @(negedge iCLK) begin
    res_t e;
    if (iRST_n && bif.oValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", bif.oValid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("count", bif.oCount, e.cnt);
        check("empty", bif.oEmpty, e.cnt == 0);
        check("xmin", bif.oXMin, e.xmin);
        check("xmax", bif.oXMax, e.xmax);
        check("ymin", bif.oYMin, e.ymin);
        check("ymax", bif.oYMax, e.ymax);
`ifdef LCD_BLOB_CENTROID_EN
        check("xsum", bif.oXSum, e.xsum);
        check("ysum", bif.oYSum, e.ysum);
`else
        check("xsum", bif.oXSum, 0);
        check("ysum", bif.oYSum, 0);
`endif
      end
    end
  end

  initial begin
    bif.iHD     = 1'b1;
    bif.iVD     = 1'b1;
    bif.iDEN    = 1'b0;
    bif.iPIX    = 8'd0;
    bif.iThresh = 8'd128;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_valid", bif.oValid, 1'b0);
    check("rst_empty", bif.oEmpty, 1'b1);
    check("rst_count", bif.oCount, 0);
    check("rst_xmin", bif.oXMin, 0);
    check("rst_xmax", bif.oXMax, 0);
    check("rst_ymin", bif.oYMin, 0);
    check("rst_ymax", bif.oYMax, 0);
    check("rst_xsum", bif.oXSum, 0);
    tick();
    iRST_n = 1'b1;
    repeat (4) tick();

    run_frame(0, 8'd128, -1);
    run_frame(0, 8'd128, -1);
    run_frame(0, 8'd128, -1);
    run_frame(1, 8'd128, -1);
    run_frame(2, 8'd128, -1);
    run_frame(3, 8'd128, -1);
    run_frame(3, 8'd127, -1);
    run_frame(4, 8'd128, -1);
    run_frame(2, 8'd128, 20);
    run_frame(2, 8'd128, -1);
    run_frame(1, 8'd128, -1);
    vsync();
    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
